// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet MAC RX counter slice.
// Holds the data-width legality check, helpers that derive beats-per-byte
// and the beat-phase register width from the receive data width, and the
// default legal frame-length limits in bytes.
package eth_rx_pkg;

  localparam int unsigned DEF_MAXFL = 1518;
  localparam int unsigned DEF_MINFL = 64;

  // Only nibble (MII) and byte (GMII) receive paths exist.
  function automatic bit dw_legal(input int unsigned dw);
    return (dw == 4) || (dw == 8);
  endfunction

  function automatic int unsigned beats_per_byte(input int unsigned dw);
    return 8 / dw;
  endfunction

  // At least one bit even when a byte arrives in a single beat.
  function automatic int unsigned phase_width(input int unsigned dw);
    return (beats_per_byte(dw) > 1) ? $clog2(beats_per_byte(dw)) : 1;
  endfunction

endpackage

// File: rtl/eth_rx_sat_counter.sv
// Generic clear / increment / saturate counter.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear (wins over increment)
//   inc_i  - increment request, ignored once the count equals SAT
//   cnt_o  - registered count
module eth_rx_sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  SAT = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_frame_counters.sv
// Receive-side counter block for the Ethernet MAC RX path.
// Supplies the beat phase within a byte, a saturating byte counter, the
// delayed-CRC window counter and the inter-frame-gap counter, and emits a
// registered end-of-frame length report with runt/oversize/dribble flags.
// Ports:
//   MRxClk, Resetn              - receive clock, async active-low reset
//   MRxDV, MRxDEq5              - data valid, data equals preamble pattern
//   StateIdle..StateDrop        - one-hot RX state from the RX FSM
//   DlyCrcEn, HugEn, r_IFG      - mode controls
//   Transmitting                - MAC transmit activity (not used here)
//   MaxFL, MinFL                - legal frame length limits in bytes
//   BeatPhase, ByteTick         - beat index in byte, byte completed
//   ByteCnt, ByteCntOut         - byte count, count incl. delayed-CRC bytes
//   ByteCntMaxFrame             - byte count reached MaxFL (unless HugEn)
//   DlyCrcCnt, IFGCounterEq     - delayed-CRC counter, IFG satisfied
//   FrameLenValid, FrameLen     - end-of-frame pulse and captured length
//   FrameTooShort/Long/Dribble  - frame status, valid with FrameLenValid
module eth_rx_frame_counters
  import eth_rx_pkg::*;
#(
  parameter int unsigned DW          = 4,
  parameter int unsigned CW          = 16,
  parameter int unsigned IFG_CYCLES  = 24,
  parameter int unsigned DLY_CRC_LEN = 9
) (
  input  logic                       MRxClk,
  input  logic                       Resetn,
  input  logic                       MRxDV,
  input  logic                       MRxDEq5,
  input  logic                       StateIdle,
  input  logic                       StatePreamble,
  input  logic                       StateSFD,
  input  logic                       StateData,
  input  logic                       StateDrop,
  input  logic                       DlyCrcEn,
  input  logic                       HugEn,
  input  logic                       Transmitting,
  input  logic                       r_IFG,
  input  logic [CW-1:0]              MaxFL,
  input  logic [CW-1:0]              MinFL,
  output logic [phase_width(DW)-1:0] BeatPhase,
  output logic                       ByteTick,
  output logic [CW-1:0]              ByteCnt,
  output logic [CW-1:0]              ByteCntOut,
  output logic                       ByteCntMaxFrame,
  output logic [3:0]                 DlyCrcCnt,
  output logic                       IFGCounterEq,
  output logic                       FrameLenValid,
  output logic [CW-1:0]              FrameLen,
  output logic                       FrameTooShort,
  output logic                       FrameTooLong,
  output logic                       FrameDribble
);

  localparam int unsigned      BPB     = beats_per_byte(DW);
  localparam int unsigned      PW      = phase_width(DW);
  localparam int unsigned      IFGW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [PW-1:0]    PH_LAST = PW'(BPB - 1);
  localparam logic [IFGW-1:0]  IFG_MAX = IFGW'(IFG_CYCLES - 1);
  localparam logic [3:0]       DLY_MAX = 4'(DLY_CRC_LEN);

  if (!dw_legal(DW)) begin : g_bad_dw
    $error("eth_rx_frame_counters: DW must be 4 or 8");
  end

  // Half-duplex gating is handled by the RX FSM; the input is kept for
  // drop-in compatibility only.
  logic unused_transmitting;
  assign unused_transmitting = Transmitting;

  // ---------------------------------------------------------------------
  // Beat phase within the current byte
  // ---------------------------------------------------------------------
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          in_pre_data;

  assign in_pre_data = StatePreamble | StateData;

  always_comb begin
    phase_d = phase_q;
    if (!MRxDV || StateIdle || StateSFD) begin
      phase_d = '0;
    end else if (in_pre_data) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    end
  end

  assign ByteTick  = MRxDV & in_pre_data & (phase_q == PH_LAST);
  assign BeatPhase = phase_q;

  // ---------------------------------------------------------------------
  // Byte counter
  // ---------------------------------------------------------------------
  logic [3:0] crc_q;
  logic [3:0] crc_d;
  logic       bc_clr;
  logic       bc_inc;

  assign ByteCntMaxFrame = (ByteCnt == MaxFL) & ~HugEn;
  assign bc_clr = StateIdle | (StateSFD & MRxDV) | (StateData & ByteCntMaxFrame & ByteTick);
  // Bytes arriving inside the delayed-CRC window are not frame bytes.
  assign bc_inc = ByteTick & ~(StateData & DlyCrcEn & (crc_q != 4'd0));

  eth_rx_sat_counter #(
    .W   (CW),
    .SAT ({CW{1'b1}})
  ) u_byte_cnt (
    .clk_i  (MRxClk),
    .rst_ni (Resetn),
    .clr_i  (bc_clr),
    .inc_i  (bc_inc),
    .cnt_o  (ByteCnt)
  );

  assign ByteCntOut = DlyCrcEn ? (ByteCnt + CW'(4)) : ByteCnt;

  // ---------------------------------------------------------------------
  // Delayed-CRC window counter
  // ---------------------------------------------------------------------
  always_comb begin
    crc_d = crc_q;
    if (crc_q == DLY_MAX) begin
      crc_d = 4'd0;
    end else if (DlyCrcEn && StateSFD) begin
      crc_d = 4'd1;
    end else if ((crc_q != 4'd0) && DlyCrcEn) begin
      crc_d = crc_q + 4'd1;
    end
  end

  assign DlyCrcCnt = crc_q;

  // ---------------------------------------------------------------------
  // Inter-frame gap counter
  // ---------------------------------------------------------------------
  logic [IFGW-1:0] ifg_cnt;
  logic            ifg_clr;
  logic            ifg_inc;

  assign ifg_clr = StateDrop | ((StateIdle | StatePreamble) & MRxDV & MRxDEq5);
  assign ifg_inc = StateIdle | StatePreamble | StateDrop;

  eth_rx_sat_counter #(
    .W   (IFGW),
    .SAT (IFG_MAX)
  ) u_ifg_cnt (
    .clk_i  (MRxClk),
    .rst_ni (Resetn),
    .clr_i  (ifg_clr),
    .inc_i  (ifg_inc),
    .cnt_o  (ifg_cnt)
  );

  assign IFGCounterEq = (ifg_cnt == IFG_MAX) | r_IFG;

  // ---------------------------------------------------------------------
  // End-of-frame report
  // ---------------------------------------------------------------------
  // EOF is the first ~MRxDV cycle after valid data; leaving StateData with
  // MRxDV still high (drop/abort) clears dv_data_q without a report.
  logic          dv_data_q;
  logic          eof;
  logic          flv_q;
  logic [CW-1:0] flen_q;
  logic          short_q;
  logic          long_q;
  logic          drib_q;

  assign eof = dv_data_q & ~MRxDV;

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      phase_q   <= '0;
      crc_q     <= 4'd0;
      dv_data_q <= 1'b0;
      flv_q     <= 1'b0;
      flen_q    <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      drib_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      crc_q     <= crc_d;
      dv_data_q <= MRxDV & StateData;
      flv_q     <= eof;
      if (eof) begin
        flen_q  <= ByteCnt;
        short_q <= ByteCnt < MinFL;
        long_q  <= ~HugEn & (ByteCnt > MaxFL);
        drib_q  <= phase_q != '0;
      end
    end
  end

  assign FrameLenValid = flv_q;
  assign FrameLen      = flen_q;
  assign FrameTooShort = short_q;
  assign FrameTooLong  = long_q;
  assign FrameDribble  = drib_q;

endmodule

// File: tb/tb_eth_rx_frame_counters.sv
// Directed bench: three instances (nibble CW=16, byte CW=16, byte CW=8)
// share the RX stimulus; each step checks only the instance it targets.
module tb_eth_rx_frame_counters;
  import eth_rx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, dv, deq5, s_idle, s_pre, s_sfd, s_data, s_drop;
  logic dlycrc, hugen, tx, rifg;
  logic [15:0] maxfl16, minfl16;
  logic [7:0]  maxfl8, minfl8;

  int tests = 0;
  int fails = 0;

  // nibble-wide, CW=16
  logic        a_ph, a_tick, a_mf, a_ifg, a_flv, a_sh, a_lg, a_dr;
  logic [15:0] a_bc, a_bco, a_fl;
  logic [3:0]  a_crc;
  // byte-wide, CW=16
  logic        b_ph, b_tick, b_mf, b_ifg, b_flv, b_sh, b_lg, b_dr;
  logic [15:0] b_bc, b_bco, b_fl;
  logic [3:0]  b_crc;
  // byte-wide, CW=8
  logic        c_ph, c_tick, c_mf, c_ifg, c_flv, c_sh, c_lg, c_dr;
  logic [7:0]  c_bc, c_bco, c_fl;
  logic [3:0]  c_crc;

  eth_rx_frame_counters #(.DW(4), .CW(16), .IFG_CYCLES(24), .DLY_CRC_LEN(9)) u4 (
    .MRxClk(clk), .Resetn(rstn), .MRxDV(dv), .MRxDEq5(deq5),
    .StateIdle(s_idle), .StatePreamble(s_pre), .StateSFD(s_sfd),
    .StateData(s_data), .StateDrop(s_drop), .DlyCrcEn(dlycrc), .HugEn(hugen),
    .Transmitting(tx), .r_IFG(rifg), .MaxFL(maxfl16), .MinFL(minfl16),
    .BeatPhase(a_ph), .ByteTick(a_tick), .ByteCnt(a_bc), .ByteCntOut(a_bco),
    .ByteCntMaxFrame(a_mf), .DlyCrcCnt(a_crc), .IFGCounterEq(a_ifg),
    .FrameLenValid(a_flv), .FrameLen(a_fl), .FrameTooShort(a_sh),
    .FrameTooLong(a_lg), .FrameDribble(a_dr));

  eth_rx_frame_counters #(.DW(8), .CW(16), .IFG_CYCLES(24), .DLY_CRC_LEN(9)) u8 (
    .MRxClk(clk), .Resetn(rstn), .MRxDV(dv), .MRxDEq5(deq5),
    .StateIdle(s_idle), .StatePreamble(s_pre), .StateSFD(s_sfd),
    .StateData(s_data), .StateDrop(s_drop), .DlyCrcEn(dlycrc), .HugEn(hugen),
    .Transmitting(tx), .r_IFG(rifg), .MaxFL(maxfl16), .MinFL(minfl16),
    .BeatPhase(b_ph), .ByteTick(b_tick), .ByteCnt(b_bc), .ByteCntOut(b_bco),
    .ByteCntMaxFrame(b_mf), .DlyCrcCnt(b_crc), .IFGCounterEq(b_ifg),
    .FrameLenValid(b_flv), .FrameLen(b_fl), .FrameTooShort(b_sh),
    .FrameTooLong(b_lg), .FrameDribble(b_dr));

  eth_rx_frame_counters #(.DW(8), .CW(8), .IFG_CYCLES(24), .DLY_CRC_LEN(9)) u8s (
    .MRxClk(clk), .Resetn(rstn), .MRxDV(dv), .MRxDEq5(deq5),
    .StateIdle(s_idle), .StatePreamble(s_pre), .StateSFD(s_sfd),
    .StateData(s_data), .StateDrop(s_drop), .DlyCrcEn(dlycrc), .HugEn(hugen),
    .Transmitting(tx), .r_IFG(rifg), .MaxFL(maxfl8), .MinFL(minfl8),
    .BeatPhase(c_ph), .ByteTick(c_tick), .ByteCnt(c_bc), .ByteCntOut(c_bco),
    .ByteCntMaxFrame(c_mf), .DlyCrcCnt(c_crc), .IFGCounterEq(c_ifg),
    .FrameLenValid(c_flv), .FrameLen(c_fl), .FrameTooShort(c_sh),
    .FrameTooLong(c_lg), .FrameDribble(c_dr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 idle, 1 preamble, 2 sfd, 3 data, 4 drop
  task automatic set_st(input int code);
    s_idle = (code == 0);
    s_pre  = (code == 1);
    s_sfd  = (code == 2);
    s_data = (code == 3);
    s_drop = (code == 4);
  endtask

  task automatic preamble_sfd(input int n);
    dv = 1'b1; deq5 = 1'b1; set_st(1);
    for (int i = 0; i < n; i++) tick();
    deq5 = 1'b0; set_st(2);
    tick();
    set_st(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; dv = 1'b0; deq5 = 1'b0; set_st(-1);
    dlycrc = 1'b0; hugen = 1'b0; tx = 1'b0; rifg = 1'b0;
    maxfl16 = 16'(DEF_MAXFL); minfl16 = 16'(DEF_MINFL);
    maxfl8 = 8'd200; minfl8 = 8'd64;

    // ---- reset state
    #12;
    chk("rst_bytecnt", a_bc, 0);
    chk("rst_bytecntout", a_bco, 0);
    chk("rst_crc", a_crc, 0);
    chk("rst_phase", a_ph, 0);
    chk("rst_flv", a_flv, 0);
    chk("rst_ifgeq", a_ifg, 0);
    dlycrc = 1'b1; #1;
    chk("rst_bytecntout_dly", a_bco, 4);
    dlycrc = 1'b0; rifg = 1'b1; #1;
    chk("rst_ifgeq_force", a_ifg, 1);
    rifg = 1'b0;
    set_st(0);
    #8 rstn = 1'b1;

    // ---- IFG: 30 idle clocks, satisfied from the 23rd onward
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("ifg_eq_%0d", k), a_ifg, (k >= 23) ? 1 : 0);
    end
    dv = 1'b1; deq5 = 1'b1;
    tick();
    chk("ifg_clear", a_ifg, 0);

    // ---- frame 1: nibble, 128 data nibbles -> 64 bytes, clean
    dv = 1'b1; deq5 = 1'b1; set_st(1);
    for (int i = 0; i < 15; i++) tick();
    chk("pre_bytecnt", a_bc, 7);
    deq5 = 1'b0; set_st(2);
    tick();
    chk("sfd_bytecnt", a_bc, 0);
    chk("sfd_phase", a_ph, 0);
    set_st(3);
    chk("tick_phase0", a_tick, 0);
    tick();
    chk("tick_phase1", a_tick, 1);
    for (int i = 1; i < 128; i++) tick();
    chk("f1_bytecnt", a_bc, 64);
    dv = 1'b0;
    chk("f1_flv_pre", a_flv, 0);
    tick();
    chk("f1_flv", a_flv, 1);
    chk("f1_len", a_fl, 64);
    chk("f1_short", a_sh, 0);
    chk("f1_long", a_lg, 0);
    chk("f1_drib", a_dr, 0);
    set_st(0);
    tick();
    chk("f1_flv_once", a_flv, 0);
    chk("f1_len_hold", a_fl, 64);

    // ---- frame 2: 61 nibbles -> 30 bytes, runt with dribble
    preamble_sfd(15);
    for (int i = 0; i < 61; i++) tick();
    chk("f2_phase", a_ph, 1);
    dv = 1'b0;
    tick();
    chk("f2_flv", a_flv, 1);
    chk("f2_len", a_fl, 30);
    chk("f2_short", a_sh, 1);
    chk("f2_drib", a_dr, 1);
    chk("f2_long", a_lg, 0);
    set_st(0);
    tick();
    chk("f2_short_hold", a_sh, 1);

    // ---- delayed CRC window: counts 1..9 then 0, bytes frozen meanwhile
    dlycrc = 1'b1;
    dv = 1'b1; deq5 = 1'b1; set_st(1);
    for (int i = 0; i < 4; i++) tick();
    chk("crc_pre", a_crc, 0);
    deq5 = 1'b0; set_st(2);
    tick();
    chk("crc_sfd", a_crc, 1);
    set_st(3);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("crc_step_%0d", i), a_crc, (i < 9) ? i + 1 : 0);
      chk($sformatf("crc_frozen_%0d", i), a_bc, 0);
    end
    for (int i = 0; i < 3; i++) tick();
    chk("crc_bytecnt", a_bc, 2);
    chk("crc_bytecntout", a_bco, 6);
    dv = 1'b0;
    tick();
    chk("crc_len", a_fl, 2);
    dlycrc = 1'b0; set_st(0);
    tick();

    // ---- byte-wide, MaxFL=1518: clear at max frame, 1600 bytes -> 81
    hugen = 1'b0;
    preamble_sfd(7);
    chk("mf_sfd", b_bc, 0);
    for (int i = 1; i <= 1600; i++) begin
      tick();
      if (i == 1517) chk("mf_1517", b_mf, 0);
      if (i == 1518) begin
        chk("mf_cnt_1518", b_bc, 1518);
        chk("mf_pulse", b_mf, 1);
      end
      if (i == 1519) chk("mf_clear", b_bc, 0);
    end
    chk("mf_bytecnt", b_bc, 81);
    chk("mf_phase", b_ph, 0);
    dv = 1'b0;
    tick();
    chk("mf_flv", b_flv, 1);
    chk("mf_len", b_fl, 81);
    chk("mf_long", b_lg, 0);
    chk("mf_short", b_sh, 0);
    set_st(0);
    tick();

    // ---- byte-wide CW=8, HugEn: saturate at 255
    hugen = 1'b1;
    preamble_sfd(7);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt", c_bc, 255);
    chk("sat_mf", c_mf, 0);
    dv = 1'b0;
    tick();
    chk("sat_flv", c_flv, 1);
    chk("sat_len", c_fl, 255);
    chk("sat_long", c_lg, 0);
    set_st(0);
    tick();

    // ---- oversize flag: MaxFL lowered below the count before EOF
    hugen = 1'b0;
    preamble_sfd(7);
    for (int i = 0; i < 100; i++) tick();
    maxfl8 = 8'd50;
    dv = 1'b0;
    tick();
    chk("long_flv", c_flv, 1);
    chk("long_len", c_fl, 100);
    chk("long_flag", c_lg, 1);
    set_st(0); maxfl8 = 8'd200;
    tick();

    // ---- reset mid-frame: async clear, no report
    preamble_sfd(3);
    for (int i = 0; i < 10; i++) tick();
    chk("rmid_cnt", a_bc, 5);
    #2 rstn = 1'b0;
    #1;
    chk("rmid_bytecnt", a_bc, 0);
    chk("rmid_bytecntout", a_bco, 0);
    chk("rmid_phase", a_ph, 0);
    chk("rmid_tick", a_tick, 0);
    chk("rmid_len", a_fl, 0);
    chk("rmid_short", a_sh, 0);
    chk("rmid_flv", a_flv, 0);
    chk("rmid_ifg", a_ifg, 0);
    dv = 1'b0; set_st(0);
    #3 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rmid_noreport_%0d", i), a_flv, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_counters.md
# eth_rx_frame_counters

Parametrised receive-side counter block for the Ethernet MAC RX path. It sits beside the RX state machine and supplies its counters:
- beat phase within a byte, for nibble (MII) or byte-wide (GMII) data;
- saturating byte counter;
- delayed-CRC counter;
- IFG counter.

It also generates a registered end-of-frame length report with runt, oversize and dribble flags, which the status/statistics logic consumes directly.

## Interface
Parameters:
- DW, 4, receive data width in bits; legal values 4 or 8; BPB = 8/DW beats per byte
- CW, 16, byte/frame counter width
- IFG_CYCLES, 24, receive clocks defining minimum inter-frame gap
- DLY_CRC_LEN, 9, length of delayed-CRC window in clocks (max 15)

Ports:
- MRxClk  in  1  receive clock; the only clock
- Resetn  in  1  asynchronous, active-low reset
- MRxDV  in  1  receive data valid
- MRxDEq5  in  1  received data equals preamble pattern
- StateIdle, StatePreamble, StateSFD, StateData, StateDrop  in  1 each  one-hot RX state
- DlyCrcEn  in  1  delayed-CRC mode
- HugEn  in  1  huge frames allowed; disables max checks
- Transmitting  in  1  MAC is transmitting
- r_IFG  in  1  force IFG satisfied
- MaxFL, MinFL  in  CW each  max/min legal frame length in bytes
- BeatPhase  out  max(1,$clog2(BPB))  beat index within current byte
- ByteTick  out  1  byte completed this cycle
- ByteCnt  out  CW  byte counter
- ByteCntOut  out  CW  ByteCnt+4 when DlyCrcEn, else ByteCnt
- ByteCntMaxFrame  out  1  ByteCnt == MaxFL & ~HugEn
- DlyCrcCnt  out  4  delayed-CRC counter
- IFGCounterEq  out  1  IFG satisfied
- FrameLenValid  out  1  one-cycle end-of-frame pulse
- FrameLen  out  CW  captured byte count
- FrameTooShort, FrameTooLong, FrameDribble  out  1 each  status, valid with FrameLenValid

## Operation
Reset: every register and output is 0. ByteCntOut is therefore 0 while DlyCrcEn=0 and 4 while DlyCrcEn=1. IFGCounterEq equals r_IFG.

Beat phase:
- Cleared when ~MRxDV, StateIdle or StateSFD.
- Otherwise advances each MRxDV cycle in StatePreamble or StateData, wrapping from BPB-1 to 0.
- ByteTick = MRxDV & (Preamble|Data) & phase==BPB-1.
- For DW=8, phase is always 0 and ByteTick = MRxDV & (Preamble|Data).

ByteCnt: clear has priority over increment.
- Clears on StateIdle, on StateSFD & MRxDV, and on StateData & ByteCntMaxFrame & ByteTick.
- Increments on ByteTick, except in StateData while DlyCrcEn & DlyCrcCnt≠0.
- Saturates at all-ones (no wrap).

DlyCrcCnt, in priority order:
- If it equals DLY_CRC_LEN, go to 0.
- Else if DlyCrcEn & StateSFD, load 1.
- Else if nonzero and DlyCrcEn, increment.

IFG counter (width $clog2(IFG_CYCLES)):
- Clears on StateDrop, or on (StateIdle|StatePreamble) & MRxDV & MRxDEq5.
- Otherwise increments in Idle/Preamble/Drop until it reaches IFG_CYCLES-1, then holds.
- IFGCounterEq = (cnt==IFG_CYCLES-1) | r_IFG.

End of frame:
- Detected when the registered MRxDV&StateData is 1 and the current MRxDV is 0.
- On the following cycle FrameLenValid=1 and FrameLen holds the ByteCnt captured at detection.
- FrameTooShort = FrameLen < MinFL.
- FrameTooLong = ~HugEn & FrameLen > MaxFL.
- FrameDribble = phase≠0 at detection.
- Flags hold until the next report.
- A frame that leaves StateData without MRxDV falling (Drop/abort) produces no report.

## Timing
- All outputs are registered except ByteTick, ByteCntOut, ByteCntMaxFrame and IFGCounterEq, which are combinational from registers and inputs.
- FrameLenValid asserts exactly 1 cycle after the first ~MRxDV cycle and is never asserted on back-to-back cycles.
- Simultaneous clear and increment on any counter: clear wins.
- Saturated ByteCnt together with end of frame: FrameLen = all-ones and FrameTooLong=1 unless HugEn.
- Resetn asserted mid-frame: immediate asynchronous clear, and no report is issued for that frame.

## Structure
- Shared package eth_rx_pkg holds the DW legality check, the BPB/width localparam functions and the default MaxFL/MinFL constants (1518/64).
- One sub-module, eth_rx_sat_counter, provides a generic clear/increment/saturate counter with parameter W. It is instantiated for ByteCnt (W=CW) and for the IFG counter (saturate value IFG_CYCLES-1). The phase, CRC and EOF logic stays in the top level.

## Test plan
- DW=4, MinFL=64, MaxFL=1518: send 15 preamble nibbles, SFD, then 128 data nibbles, then drop MRxDV -> one FrameLenValid pulse, FrameLen=64, all flags 0.
- DW=4: 61 data nibbles -> FrameLen=30, FrameTooShort=1, FrameDribble=1.
- DW=8, HugEn=0, MaxFL=1518: 1600 data bytes -> ByteCntMaxFrame pulses at 1518, ByteCnt clears, and reporting follows the clear rule.
- DW=8, CW=8, HugEn=1: 300 data bytes -> ByteCnt holds at 255, FrameLen=255, FrameTooLong=0.
- DlyCrcEn=1 with SFD -> DlyCrcCnt steps 1..9 then 0, ByteCnt frozen during those cycles, and ByteCntOut = ByteCnt+4.
- Idle for 30 clocks, then MRxDV with MRxDEq5 -> IFGCounterEq=1 from cycle 23 onward, and the counter clears to 0 the next cycle; Resetn pulse mid-data -> all outputs 0 and no FrameLenValid.
